// File: rtl/lsu_mem_port.sv
// -----------------------------------------------------------------------------
// lsu_mem_port
//
// Memory-side responder for the core's data-memory control signals. One
// load/store is accepted per start pulse while idle. The access is performed on
// a 64-bit, doubleword-aligned valid/ready bus. An access whose bytes straddle a
// doubleword boundary is split into two bus beats. Load data is returned
// right-justified and sign- or zero-extended. The core is stalled while the
// access is in flight.
//
// Ports
//   clk, rst      clock; asynchronous active-high reset
//   start         one-cycle request from the datapath (sampled only when idle)
//   memrw         0 = load, 1 = store
//   memword       access size: 00 byte, 01 half, 10 word, 11 double
//   memsign       1 = zero-extend load, 0 = sign-extend load
//   addr          byte address of the access
//   wdata         store data, right-justified
//   stall         hold the pipeline (combinational, high in the start cycle)
//   done          one-cycle completion pulse
//   rdata         extended load result, held from done until the next load
//   req_*         bus request channel (valid/ready), doubleword-aligned address,
//                 lane-positioned write data and byte strobes
//   resp_valid    bus response (read data or write acknowledge), always accepted
//   resp_rdata    bus read data
//
// The byte-strobe width (8) fixes the bus at 64 bits, so XLEN must be 64.
// -----------------------------------------------------------------------------
module lsu_mem_port #(
  parameter int XLEN = 64,
  parameter int AW   = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            memrw,
  input  logic [1:0]      memword,
  input  logic            memsign,
  input  logic [AW-1:0]   addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] rdata,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [AW-1:0]   req_addr,
  output logic            req_we,
  output logic [XLEN-1:0] req_wdata,
  output logic [7:0]      req_wstrb,
  input  logic            resp_valid,
  input  logic [XLEN-1:0] resp_rdata
);

  // ---------------------------------------------------------------------------
  // State encoding
  // ---------------------------------------------------------------------------
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ0 = 3'd1;
  localparam logic [2:0] RSP0 = 3'd2;
  localparam logic [2:0] REQ1 = 3'd3;
  localparam logic [2:0] RSP1 = 3'd4;

  logic [2:0]      state;

  // Request captured at start; the datapath is free to change its outputs
  // afterwards because it is stalled only by our stall output.
  logic            r_we;
  logic [1:0]      r_word;
  logic            r_sign;
  logic [2:0]      r_off;
  logic            r_cross;
  logic [7:0]      r_strb_hi;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_lo;

  // ---------------------------------------------------------------------------
  // Beat geometry of the incoming request
  // ---------------------------------------------------------------------------
  logic [2:0]  in_off;
  logic [3:0]  in_size;
  logic [15:0] in_mask;
  logic        in_cross;

  // NOTE: every variable of a combinational block is assigned on every path
  // through it; a path that leaves one unassigned would infer a latch.
  always_comb begin
    in_off   = addr[2:0];
    in_size  = 4'd1 << memword;
    // Byte mask across two consecutive doublewords: bits [7:0] belong to the
    // first beat, bits [15:8] to the second.
    in_mask  = ((16'd1 << in_size) - 16'd1) << in_off;
    in_cross = ({1'b0, in_off} + in_size) > 4'd8;
  end

  // ---------------------------------------------------------------------------
  // Load result assembly
  // ---------------------------------------------------------------------------
  function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] v,
                                                  input logic [1:0]      word,
                                                  input logic            zext);
    logic [XLEN-1:0] r;
    case (word)
      2'b00:   r = {{(XLEN-8){~zext & v[7]}},   v[7:0]};
      2'b01:   r = {{(XLEN-16){~zext & v[15]}}, v[15:0]};
      2'b10:   r = {{(XLEN-32){~zext & v[31]}}, v[31:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  logic [2*XLEN-1:0] ld_raw;
  logic [XLEN-1:0]   ld_aligned;
  logic [XLEN-1:0]   ld_ext;
  logic              finish;

  always_comb begin
    // In RSP1 the second doubleword is arriving on the bus; in RSP0 only the
    // first one exists and the upper half is never reached by the truncation.
    ld_raw     = (state == RSP1) ? {resp_rdata, r_lo} : {{XLEN{1'b0}}, resp_rdata};
    ld_aligned = XLEN'(ld_raw >> {r_off, 3'b000});
    ld_ext     = extend_load(ld_aligned, r_word, r_sign);
    finish     = resp_valid && (((state == RSP0) && !r_cross) || (state == RSP1));
  end

  // The core must already hold in the cycle it presents start.
  assign stall = start | (state != IDLE);

  // ---------------------------------------------------------------------------
  // Sequencer and bus request registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and evaluation order inside the block is moot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the captured request fields are reset as well although they are
      // don't-care while idle; it keeps X out of the req_* lanes and rdata.
      state     <= IDLE;
      r_we      <= 1'b0;
      r_word    <= 2'b00;
      r_sign    <= 1'b0;
      r_off     <= 3'd0;
      r_cross   <= 1'b0;
      r_strb_hi <= 8'h00;
      r_wdata   <= '0;
      r_lo      <= '0;
      req_valid <= 1'b0;
      req_addr  <= '0;
      req_we    <= 1'b0;
      req_wdata <= '0;
      req_wstrb <= 8'h00;
      done      <= 1'b0;
      rdata     <= '0;
    end else begin
      done <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            r_we      <= memrw;
            r_word    <= memword;
            r_sign    <= memsign;
            r_off     <= in_off;
            r_cross   <= in_cross;
            r_wdata   <= wdata;
            // Strobes are write enables: a read carries none.
            r_strb_hi <= memrw ? in_mask[15:8] : 8'h00;
            req_valid <= 1'b1;
            req_addr  <= {addr[AW-1:3], 3'b000};
            req_we    <= memrw;
            req_wdata <= wdata << {in_off, 3'b000};
            req_wstrb <= memrw ? in_mask[7:0] : 8'h00;
            state     <= REQ0;
          end
        end

        // Request fields are left untouched until the handshake so they stay
        // stable under backpressure.
        REQ0: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            state     <= RSP0;
          end
        end

        RSP0: begin
          if (resp_valid) begin
            r_lo <= resp_rdata;
            if (r_cross) begin
              // Second beat: the bytes shifted out the top of the first beat.
              // r_off is non-zero whenever the access crosses.
              req_valid <= 1'b1;
              req_addr  <= req_addr + AW'(8);
              req_wdata <= r_wdata >> (7'd64 - {1'b0, r_off, 3'b000});
              req_wstrb <= r_strb_hi;
              state     <= REQ1;
            end else begin
              state <= IDLE;
            end
          end
        end

        REQ1: begin
          if (req_ready) begin
            req_valid <= 1'b0;
            state     <= RSP1;
          end
        end

        RSP1: begin
          if (resp_valid) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

      if (finish) begin
        done <= 1'b1;
        // Stores complete with an acknowledge only; the last load value stays.
        if (!r_we) begin
          rdata <= ld_ext;
        end
      end
    end
  end

endmodule
